// File: rtl/wave_pkg.sv
// Shared defaults and FSM state encoding for the waveform peak/trough/period analyzer.
package wave_pkg;

    localparam int SAMPLE_W_DEF = 8;
    localparam int PERIOD_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RISING  = 2'd1,
        FALLING = 2'd2
    } wave_state_e;

endpackage

// File: rtl/wave_analyzer_sat_counter.sv
// Saturating up-counter: synchronous clear-to-0, load-to-1, enable, holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_one,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_one) begin
            cnt_d = WIDTH'(1);
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/wave_analyzer.sv
// Tracks a sampled waveform, reporting last peak, last trough and the sample count between troughs.
// Define WAVE_ANALYZER_HYST_EN to require a HYST-LSB excursion before a direction reversal is accepted.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | after reset; first valid sample seeds the running minimum
// RISING  | tracking run_max, waiting for a drop that marks a peak
// FALLING | tracking run_min, waiting for a rise that marks a trough
module wave_analyzer
    import wave_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int HYST     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                sample_valid,
    output logic [SAMPLE_W-1:0] peak,
    output logic [SAMPLE_W-1:0] trough,
    output logic [PERIOD_W-1:0] period,
    output logic                measure_valid,
    output logic                rising
);

    localparam logic [SAMPLE_W:0] HYST_X  = (SAMPLE_W + 1)'(HYST);
    localparam logic [SAMPLE_W:0] MAX_X   = {1'b0, {SAMPLE_W{1'b1}}};

    wave_state_e         state_q, state_d;
    logic [SAMPLE_W-1:0] run_max_q, run_max_d;
    logic [SAMPLE_W-1:0] run_min_q, run_min_d;
    logic [SAMPLE_W-1:0] peak_q, peak_d;
    logic [SAMPLE_W-1:0] trough_q, trough_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                mv_q, mv_d;
    logic                have_trough_q, have_trough_d;

    logic                peak_det;
    logic                trough_det;
    logic                cnt_clr;
    logic                cnt_load_one;
    logic                cnt_en;
    logic [PERIOD_W-1:0] cnt;

`ifdef WAVE_ANALYZER_HYST_EN
    logic [SAMPLE_W:0] peak_thr;
    logic [SAMPLE_W:0] trough_thr;
    logic [SAMPLE_W:0] trough_sum;

    always_comb begin
        peak_thr   = ({1'b0, run_max_q} >= HYST_X) ? ({1'b0, run_max_q} - HYST_X) : '0;
        trough_sum = {1'b0, run_min_q} + HYST_X;
        trough_thr = (trough_sum > MAX_X) ? MAX_X : trough_sum;
        peak_det   = {1'b0, sample} < peak_thr;
        trough_det = {1'b0, sample} > trough_thr;
    end
`else
    logic [2*SAMPLE_W+1:0] unused_hyst;
    assign unused_hyst = {HYST_X, MAX_X};

    always_comb begin
        peak_det   = sample < run_max_q;
        trough_det = sample > run_min_q;
    end
`endif

    always_comb begin
        state_d       = state_q;
        run_max_d     = run_max_q;
        run_min_d     = run_min_q;
        peak_d        = peak_q;
        trough_d      = trough_q;
        period_d      = period_q;
        have_trough_d = have_trough_q;
        mv_d          = 1'b0;
        cnt_clr       = 1'b0;
        cnt_load_one  = 1'b0;
        cnt_en        = 1'b0;

        if (sample_valid) begin
            case (state_q)
                IDLE: begin
                    run_min_d     = sample;
                    have_trough_d = 1'b0;
                    cnt_clr       = 1'b1;
                    state_d       = FALLING;
                end
                RISING: begin
                    cnt_en = 1'b1;
                    if (peak_det) begin
                        peak_d    = run_max_q;
                        run_min_d = sample;
                        state_d   = FALLING;
                    end else if (sample > run_max_q) begin
                        run_max_d = sample;
                    end
                end
                FALLING: begin
                    if (trough_det) begin
                        trough_d     = run_min_q;
                        run_max_d    = sample;
                        state_d      = RISING;
                        cnt_load_one = 1'b1;
                        // The very first trough only opens the measurement window.
                        if (have_trough_q) begin
                            period_d = cnt;
                            mv_d     = 1'b1;
                        end else begin
                            have_trough_d = 1'b1;
                        end
                    end else begin
                        cnt_en = 1'b1;
                        if (sample < run_min_q) begin
                            run_min_d = sample;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            run_max_q     <= '0;
            run_min_q     <= '0;
            peak_q        <= '0;
            trough_q      <= '0;
            period_q      <= '0;
            mv_q          <= 1'b0;
            have_trough_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            run_max_q     <= run_max_d;
            run_min_q     <= run_min_d;
            peak_q        <= peak_d;
            trough_q      <= trough_d;
            period_q      <= period_d;
            mv_q          <= mv_d;
            have_trough_q <= have_trough_d;
        end
    end

    sat_counter #(
        .WIDTH (PERIOD_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst | cnt_clr),
        .load_one (cnt_load_one),
        .en       (cnt_en),
        .cnt      (cnt)
    );

    assign peak          = peak_q;
    assign trough        = trough_q;
    assign period        = period_q;
    assign measure_valid = mv_q;
    assign rising        = (state_q == RISING);

endmodule
